// File: rtl/dcache_flush_unit_if.sv
// Memory port bundle between the dcache flush engine (master) and data memory (slave).
// Signal names keep the flush unit's point of view: _o leaves the engine, _i enters it.
interface dcache_flush_unit_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
);
    logic              mem_enable_o;
    logic              mem_write_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [LINE_W-1:0] mem_data_o;
    logic              mem_ack_i;

    modport master (
        output mem_enable_o,
        output mem_write_o,
        output mem_addr_o,
        output mem_data_o,
        input  mem_ack_i
    );

    modport slave (
        input  mem_enable_o,
        input  mem_write_o,
        input  mem_addr_o,
        input  mem_data_o,
        output mem_ack_i
    );
endinterface

// File: rtl/dcache_flush_unit.sv
// Flush engine and access monitor for the write-back, direct-mapped data cache.
// On request it stalls the cache, scans every line, writes back each valid dirty
// line over the memory handshake and then clears that line's dirty bit.
// Optional feature macro: DCACHE_FLUSH_STATS_EN enables saturating access and
// write-back counters; without it the counter outputs are tied to zero.
module dcache_flush_unit #(
    parameter int NUM_LINES = 32,
    parameter int IDX_W     = $clog2(NUM_LINES),
    parameter int LINE_W    = 256,
    parameter int OFFSET_W  = 5,
    parameter int ADDR_W    = 32,
    parameter int TAG_W     = ADDR_W - IDX_W - OFFSET_W,
    parameter int CNT_W     = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,

    input  logic                 flush_req_i,
    input  logic                 cache_idle_i,
    output logic                 flush_busy_o,
    output logic                 flush_done_o,

    output logic [IDX_W-1:0]     line_idx_o,
    output logic                 line_rd_o,
    input  logic                 line_valid_i,
    input  logic                 line_dirty_i,
    input  logic [TAG_W-1:0]     line_tag_i,
    input  logic [LINE_W-1:0]    line_data_i,
    output logic                 line_clean_o,

    dcache_flush_unit_if.master  mem_if,

    input  logic                 acc_valid_i,
    input  logic                 acc_write_i,
    input  logic                 acc_hit_i,
    input  logic                 acc_wb_i,
    input  logic                 stats_clr_i,
    output logic [CNT_W-1:0]     rd_hit_o,
    output logic [CNT_W-1:0]     rd_miss_o,
    output logic [CNT_W-1:0]     wr_hit_o,
    output logic [CNT_W-1:0]     wr_miss_o,
    output logic [CNT_W-1:0]     wb_cnt_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LINES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_IDLE,
        S_READ,
        S_CHECK,
        S_WRITE,
        S_CLEAN,
        S_NEXT,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_stateNext;
    logic [IDX_W-1:0]    r_idx;
    logic [ADDR_W-1:0]   r_memAddr;
    logic [LINE_W-1:0]   r_memData;

    logic                w_idxClear;
    logic                w_idxInc;
    logic                w_capture;
    logic                w_memEnable;
    logic                w_flushWb;

    // State register, scan index and the latched write-back address/data
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_memAddr <= '0;
            r_memData <= '0;
        end else begin
            r_state <= w_stateNext;
            if (w_idxClear) begin
                r_idx <= '0;
            end else if (w_idxInc) begin
                r_idx <= r_idx + 1'b1;
            end
            if (w_capture) begin
                r_memAddr <= {line_tag_i, r_idx, {OFFSET_W{1'b0}}};
                r_memData <= line_data_i;
            end
        end
    end

    // Next-state decode and per-state control outputs; the scan never wraps past the last line
    always_comb begin
        w_stateNext  = r_state;
        w_idxClear   = 1'b0;
        w_idxInc     = 1'b0;
        w_capture    = 1'b0;
        w_memEnable  = 1'b0;
        w_flushWb    = 1'b0;
        flush_busy_o = 1'b0;
        flush_done_o = 1'b0;
        line_rd_o    = 1'b0;
        line_clean_o = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (flush_req_i) begin
                    w_idxClear  = 1'b1;
                    w_stateNext = cache_idle_i ? S_READ : S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                flush_busy_o = 1'b1;
                if (cache_idle_i) begin
                    w_stateNext = S_READ;
                end
            end
            S_READ: begin
                flush_busy_o = 1'b1;
                line_rd_o    = 1'b1;
                w_stateNext  = S_CHECK;
            end
            S_CHECK: begin
                flush_busy_o = 1'b1;
                if (line_valid_i && line_dirty_i) begin
                    w_capture   = 1'b1;
                    w_stateNext = S_WRITE;
                end else begin
                    w_stateNext = S_NEXT;
                end
            end
            S_WRITE: begin
                flush_busy_o = 1'b1;
                w_memEnable  = 1'b1;
                if (mem_if.mem_ack_i) begin
                    w_flushWb   = 1'b1;
                    w_stateNext = S_CLEAN;
                end
            end
            S_CLEAN: begin
                flush_busy_o = 1'b1;
                line_clean_o = 1'b1;
                w_stateNext  = S_NEXT;
            end
            S_NEXT: begin
                flush_busy_o = 1'b1;
                if (r_idx == LAST_IDX) begin
                    w_stateNext = S_DONE;
                end else begin
                    w_idxInc    = 1'b1;
                    w_stateNext = S_READ;
                end
            end
            S_DONE: begin
                flush_done_o = 1'b1;
                w_stateNext  = S_IDLE;
            end
            default: begin
                w_stateNext = S_IDLE;
            end
        endcase
    end

    assign line_idx_o          = r_idx;
    assign mem_if.mem_enable_o = w_memEnable;
    assign mem_if.mem_write_o  = w_memEnable;
    assign mem_if.mem_addr_o   = r_memAddr;
    assign mem_if.mem_data_o   = r_memData;

`ifdef DCACHE_FLUSH_STATS_EN

    logic [CNT_W-1:0] r_rdHit;
    logic [CNT_W-1:0] r_rdMiss;
    logic [CNT_W-1:0] r_wrHit;
    logic [CNT_W-1:0] r_wrMiss;
    logic [CNT_W-1:0] r_wbCnt;

    logic             w_rdHitInc;
    logic             w_rdMissInc;
    logic             w_wrHitInc;
    logic             w_wrMissInc;
    logic [1:0]       w_wbInc;

    // Add a small increment and clamp at the all-ones value instead of wrapping
    function automatic logic [CNT_W-1:0] satAdd(input logic [CNT_W-1:0] value,
                                                input logic [1:0]       inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, value} + (CNT_W+1)'(inc);
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

    assign w_rdHitInc  = acc_valid_i && !acc_write_i &&  acc_hit_i;
    assign w_rdMissInc = acc_valid_i && !acc_write_i && !acc_hit_i;
    assign w_wrHitInc  = acc_valid_i &&  acc_write_i &&  acc_hit_i;
    assign w_wrMissInc = acc_valid_i &&  acc_write_i && !acc_hit_i;
    assign w_wbInc     = {1'b0, acc_valid_i && acc_wb_i} + {1'b0, w_flushWb};

    // Saturating statistics counters; a clear wins over any increment in the same cycle
    always_ff @(posedge clk_i) begin
        if (rst_i || stats_clr_i) begin
            r_rdHit  <= '0;
            r_rdMiss <= '0;
            r_wrHit  <= '0;
            r_wrMiss <= '0;
            r_wbCnt  <= '0;
        end else begin
            r_rdHit  <= satAdd(r_rdHit,  {1'b0, w_rdHitInc});
            r_rdMiss <= satAdd(r_rdMiss, {1'b0, w_rdMissInc});
            r_wrHit  <= satAdd(r_wrHit,  {1'b0, w_wrHitInc});
            r_wrMiss <= satAdd(r_wrMiss, {1'b0, w_wrMissInc});
            r_wbCnt  <= satAdd(r_wbCnt,  w_wbInc);
        end
    end

    assign rd_hit_o  = r_rdHit;
    assign rd_miss_o = r_rdMiss;
    assign wr_hit_o  = r_wrHit;
    assign wr_miss_o = r_wrMiss;
    assign wb_cnt_o  = r_wbCnt;

`else

    // Statistics are compiled out: inputs are ignored and counts read as zero
    logic w_unusedStats;
    assign w_unusedStats = ^{acc_valid_i, acc_write_i, acc_hit_i, acc_wb_i,
                             stats_clr_i, w_flushWb};

    assign rd_hit_o  = '0;
    assign rd_miss_o = '0;
    assign wr_hit_o  = '0;
    assign wr_miss_o = '0;
    assign wb_cnt_o  = '0;

`endif

endmodule

// File: tb/tb_dcache_flush_unit.sv
// Self-checking bench for dcache_flush_unit: models the tag/data SRAM and the
// data memory, keeps a scoreboard of expected write-backs and line cleans, and
// checks flush timing, reset behaviour and (when built with
// DCACHE_FLUSH_STATS_EN) the saturating statistics counters.
module tb_dcache_flush_unit;

    localparam int NUM_LINES = 32;
    localparam int IDX_W     = 5;
    localparam int LINE_W    = 256;
    localparam int OFFSET_W  = 5;
    localparam int ADDR_W    = 32;
    localparam int TAG_W     = ADDR_W - IDX_W - OFFSET_W;
`ifdef DCACHE_FLUSH_STATS_EN
    localparam int CNT_W    = 4;
    localparam bit STATS_EN = 1'b1;
`else
    localparam int CNT_W    = 32;
    localparam bit STATS_EN = 1'b0;
`endif
    localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;

    logic                clk_i = 1'b0;
    logic                rst_i;
    logic                flush_req_i;
    logic                cache_idle_i;
    logic                flush_busy_o;
    logic                flush_done_o;
    logic [IDX_W-1:0]    line_idx_o;
    logic                line_rd_o;
    logic                line_valid_i;
    logic                line_dirty_i;
    logic [TAG_W-1:0]    line_tag_i;
    logic [LINE_W-1:0]   line_data_i;
    logic                line_clean_o;
    logic                acc_valid_i;
    logic                acc_write_i;
    logic                acc_hit_i;
    logic                acc_wb_i;
    logic                stats_clr_i;
    logic [CNT_W-1:0]    rd_hit_o;
    logic [CNT_W-1:0]    rd_miss_o;
    logic [CNT_W-1:0]    wr_hit_o;
    logic [CNT_W-1:0]    wr_miss_o;
    logic [CNT_W-1:0]    wb_cnt_o;

    dcache_flush_unit_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) memIf ();

    dcache_flush_unit #(
        .NUM_LINES (NUM_LINES),
        .LINE_W    (LINE_W),
        .OFFSET_W  (OFFSET_W),
        .ADDR_W    (ADDR_W),
        .CNT_W     (CNT_W)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .flush_req_i  (flush_req_i),
        .cache_idle_i (cache_idle_i),
        .flush_busy_o (flush_busy_o),
        .flush_done_o (flush_done_o),
        .line_idx_o   (line_idx_o),
        .line_rd_o    (line_rd_o),
        .line_valid_i (line_valid_i),
        .line_dirty_i (line_dirty_i),
        .line_tag_i   (line_tag_i),
        .line_data_i  (line_data_i),
        .line_clean_o (line_clean_o),
        .mem_if       (memIf),
        .acc_valid_i  (acc_valid_i),
        .acc_write_i  (acc_write_i),
        .acc_hit_i    (acc_hit_i),
        .acc_wb_i     (acc_wb_i),
        .stats_clr_i  (stats_clr_i),
        .rd_hit_o     (rd_hit_o),
        .rd_miss_o    (rd_miss_o),
        .wr_hit_o     (wr_hit_o),
        .wr_miss_o    (wr_miss_o),
        .wb_cnt_o     (wb_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] data;
    } wbExp_t;

    wbExp_t            writeQ[$];
    int                cleanQ[$];

    logic              modelValid [NUM_LINES];
    logic              modelDirty [NUM_LINES];
    logic [TAG_W-1:0]  modelTag   [NUM_LINES];
    logic [LINE_W-1:0] modelData  [NUM_LINES];

    int vectorCount     = 0;
    int miscompareCount = 0;
    int ackLatency      = 1;
    int enCount         = 0;
    int enableCycles    = 0;
    int writeCount      = 0;
    int cleanCount      = 0;
    int doneCount       = 0;
    logic [ADDR_W-1:0] firstAddr;

    longint expRdHit, expRdMiss, expWrHit, expWrMiss, expWb;

    // Single comparison point: counts every vector and reports any miscompare
    task automatic checkOutput(input string tag, input logic [LINE_W-1:0] observed,
                               input logic [LINE_W-1:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            miscompareCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic longint satInc(input longint value);
        if (!STATS_EN) return 0;
        return (value < CNT_MAX) ? value + 1 : value;
    endfunction

    // Program one cache line in the SRAM model and queue the write-back it should cause
    task automatic applyStimulus(input int idx, input logic valid, input logic dirty,
                                 input logic [TAG_W-1:0] tag, input logic [LINE_W-1:0] data);
        wbExp_t e;
        modelValid[idx] = valid;
        modelDirty[idx] = dirty;
        modelTag[idx]   = tag;
        modelData[idx]  = data;
        if (valid && dirty) begin
            e.addr = {tag, IDX_W'(idx), {OFFSET_W{1'b0}}};
            e.data = data;
            writeQ.push_back(e);
            cleanQ.push_back(idx);
        end
    endtask

    task automatic clearCache();
        for (int i = 0; i < NUM_LINES; i++) begin
            modelValid[i] = 1'b0;
            modelDirty[i] = 1'b0;
            modelTag[i]   = '0;
            modelData[i]  = '0;
        end
        writeQ.delete();
        cleanQ.delete();
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "Busy"},   flush_busy_o, 0);
        checkOutput({tag, "Done"},   flush_done_o, 0);
        checkOutput({tag, "LineRd"}, line_rd_o, 0);
        checkOutput({tag, "Clean"},  line_clean_o, 0);
        checkOutput({tag, "Idx"},    line_idx_o, 0);
        checkOutput({tag, "MemEn"},  memIf.mem_enable_o, 0);
        checkOutput({tag, "MemWr"},  memIf.mem_write_o, 0);
        checkOutput({tag, "Addr"},   memIf.mem_addr_o, 0);
        checkOutput({tag, "Data"},   memIf.mem_data_o, 0);
        checkOutput({tag, "WbCnt"},  wb_cnt_o, 0);
    endtask

    // Issue one flush request and follow it to the done pulse, checking timing and side effects
    task automatic runFlush(input string tag, input int idleDelay, input int midReqCycle,
                            input int expDone, input int expWrites);
        int c;
        int doneAt;
        int busyCycles;
        writeCount   = 0;
        cleanCount   = 0;
        doneCount    = 0;
        enableCycles = 0;
        @(negedge clk_i);
        cache_idle_i = (idleDelay == 0);
        flush_req_i  = 1'b1;
        @(negedge clk_i);
        flush_req_i = 1'b0;
        c          = 1;
        doneAt     = -1;
        busyCycles = 0;
        while (doneAt < 0 && c <= expDone + 40) begin
            if (c == 1 && idleDelay == 0)
                checkOutput({tag, "FirstRead"}, {line_rd_o, line_idx_o}, {1'b1, IDX_W'(0)});
            if (c == idleDelay) cache_idle_i = 1'b1;
            flush_req_i = (c == midReqCycle);
            if (flush_busy_o) busyCycles++;
            if (flush_done_o) begin
                doneAt = c;
            end else begin
                @(negedge clk_i);
                c++;
            end
        end
        flush_req_i = 1'b0;
        if (doneAt < 0) begin
            checkOutput({tag, "DoneTimeout"}, 0, 1);
        end else begin
            checkOutput({tag, "DoneCycle"}, doneAt, expDone);
            checkOutput({tag, "BusyCycles"}, busyCycles, expDone - 1);
            checkOutput({tag, "BusyAtDone"}, flush_busy_o, 0);
        end
        repeat (20) @(negedge clk_i);
        checkOutput({tag, "DonePulses"}, doneCount, 1);
        checkOutput({tag, "BusyAfter"}, flush_busy_o, 0);
        checkOutput({tag, "Writes"}, writeCount, expWrites);
        checkOutput({tag, "Cleans"}, cleanCount, expWrites);
        checkOutput({tag, "EnableCycles"}, enableCycles, expWrites * ackLatency);
        checkOutput({tag, "PendingWrites"}, writeQ.size(), 0);
        checkOutput({tag, "PendingCleans"}, cleanQ.size(), 0);
    endtask

    task automatic accEvent(input logic isWrite, input logic isHit, input logic isWb);
        @(negedge clk_i);
        acc_valid_i = 1'b1;
        acc_write_i = isWrite;
        acc_hit_i   = isHit;
        acc_wb_i    = isWb;
        @(negedge clk_i);
        acc_valid_i = 1'b0;
        acc_write_i = 1'b0;
        acc_hit_i   = 1'b0;
        acc_wb_i    = 1'b0;
    endtask

    task automatic checkStats(input string tag);
        checkOutput({tag, "RdHit"},  rd_hit_o,  CNT_W'(expRdHit));
        checkOutput({tag, "RdMiss"}, rd_miss_o, CNT_W'(expRdMiss));
        checkOutput({tag, "WrHit"},  wr_hit_o,  CNT_W'(expWrHit));
        checkOutput({tag, "WrMiss"}, wr_miss_o, CNT_W'(expWrMiss));
        checkOutput({tag, "WbCnt"},  wb_cnt_o,  CNT_W'(expWb));
    endtask

    // SRAM and memory model plus scoreboard: answers reads, acks writes, pops expectations
    always @(negedge clk_i) begin
        if (rst_i) begin
            enCount          = 0;
            memIf.mem_ack_i  = 1'b0;
        end else begin
            if (line_rd_o) begin
                line_valid_i = modelValid[line_idx_o];
                line_dirty_i = modelDirty[line_idx_o];
                line_tag_i   = modelTag[line_idx_o];
                line_data_i  = modelData[line_idx_o];
            end
            if (memIf.mem_enable_o) begin
                enCount++;
                enableCycles++;
                if (enCount == 1) firstAddr = memIf.mem_addr_o;
                if (enCount == ackLatency) begin
                    memIf.mem_ack_i = 1'b1;
                    writeCount++;
                    if (writeQ.size() == 0) begin
                        checkOutput("unexpectedWrite", 1, 0);
                    end else begin
                        wbExp_t e;
                        e = writeQ.pop_front();
                        checkOutput("wbAddr", memIf.mem_addr_o, e.addr);
                        checkOutput("wbAddrHeld", firstAddr, e.addr);
                        checkOutput("wbData", memIf.mem_data_o, e.data);
                        checkOutput("wbWriteFlag", memIf.mem_write_o, 1);
                    end
                end else begin
                    memIf.mem_ack_i = 1'b0;
                end
            end else begin
                enCount         = 0;
                memIf.mem_ack_i = 1'b0;
            end
            if (line_clean_o) begin
                cleanCount++;
                if (cleanQ.size() == 0) begin
                    checkOutput("unexpectedClean", 1, 0);
                end else begin
                    checkOutput("cleanIdx", line_idx_o, cleanQ.pop_front());
                end
                modelDirty[line_idx_o] = 1'b0;
            end
            if (flush_done_o) doneCount++;
        end
    end

    initial begin
        logic [LINE_W-1:0] pattern;
        logic [LINE_W-1:0] rnd;
        rst_i           = 1'b1;
        flush_req_i     = 1'b0;
        cache_idle_i    = 1'b1;
        acc_valid_i     = 1'b0;
        acc_write_i     = 1'b0;
        acc_hit_i       = 1'b0;
        acc_wb_i        = 1'b0;
        stats_clr_i     = 1'b0;
        memIf.mem_ack_i = 1'b0;
        line_valid_i    = 1'b0;
        line_dirty_i    = 1'b0;
        line_tag_i      = '0;
        line_data_i     = '0;
        clearCache();
        repeat (3) @(negedge clk_i);
        checkAllZero("reset");
        rst_i = 1'b0;

        // Statistics: saturation, write-miss with write-back, clear and clear priority
        expRdHit = 0; expRdMiss = 0; expWrHit = 0; expWrMiss = 0; expWb = 0;
        for (int i = 0; i < 20; i++) begin
            accEvent(1'b0, 1'b1, 1'b0);
            expRdHit = satInc(expRdHit);
        end
        checkStats("statsRdHit");
        accEvent(1'b1, 1'b0, 1'b1);
        accEvent(1'b1, 1'b0, 1'b0);
        expWrMiss = satInc(satInc(expWrMiss));
        expWb     = satInc(expWb);
        checkStats("statsWrMiss");
        @(negedge clk_i);
        stats_clr_i = 1'b1;
        acc_valid_i = 1'b1;
        acc_hit_i   = 1'b1;
        @(negedge clk_i);
        stats_clr_i = 1'b0;
        acc_valid_i = 1'b0;
        acc_hit_i   = 1'b0;
        expRdHit = 0; expRdMiss = 0; expWrHit = 0; expWrMiss = 0; expWb = 0;
        checkStats("statsClr");

        // All lines clean: no memory traffic, done 97 cycles after the request edge
        clearCache();
        ackLatency = 1;
        runFlush("clean", 0, 0, NUM_LINES * 3 + 1, 0);

        // Line 3 valid and dirty with a 10-cycle memory: one write-back to 0x460
        clearCache();
        ackLatency = 10;
        pattern = {32{8'hA5}};
        applyStimulus(3, 1'b1, 1'b1, 22'h1, pattern);
        checkOutput("line3Addr", writeQ[0].addr, 32'h0000_0460);
        runFlush("dirty3", 0, 0, NUM_LINES * 3 + 1 + 11, 1);
        checkOutput("dirty3WbCnt", wb_cnt_o, CNT_W'(satInc(0)));

        // Invalid-dirty and valid-clean lines must never be written
        clearCache();
        ackLatency = 1;
        applyStimulus(7, 1'b0, 1'b1, 22'h3F, '1);
        applyStimulus(8, 1'b1, 1'b0, 22'h2A, '1);
        runFlush("noWrite", 0, 0, NUM_LINES * 3 + 1, 0);

        // Several dirty lines, including the first and last, with a 2-cycle memory
        clearCache();
        ackLatency = 2;
        for (int i = 0; i < NUM_LINES; i++) begin
            rnd = {8{$urandom()}};
            if (i == 0 || i == 12 || i == NUM_LINES - 1)
                applyStimulus(i, 1'b1, 1'b1, TAG_W'($urandom()), rnd);
        end
        runFlush("multi", 0, 0, NUM_LINES * 3 + 1 + 3 * 3, 3);

        // Cache busy for 5 cycles and a second request mid-flush that must be ignored
        clearCache();
        ackLatency = 1;
        runFlush("waitIdle", 5, 50, 5 + NUM_LINES * 3 + 1, 0);

        // Reset while line 5 is being written: everything drops, no done, restart from 0
        clearCache();
        ackLatency = 1000;
        rnd = {8{$urandom()}};
        applyStimulus(5, 1'b1, 1'b1, 22'h155, rnd);
        doneCount = 0;
        @(negedge clk_i);
        flush_req_i = 1'b1;
        @(negedge clk_i);
        flush_req_i = 1'b0;
        begin
            int waitCycles;
            waitCycles = 0;
            while (!memIf.mem_enable_o && waitCycles < 200) begin
                @(negedge clk_i);
                waitCycles++;
            end
            checkOutput("rstWriteSeen", memIf.mem_enable_o, 1);
            checkOutput("rstWriteIdx", line_idx_o, 5);
        end
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        checkAllZero("midReset");
        repeat (10) @(negedge clk_i);
        checkOutput("midResetNoDone", doneCount, 0);
        writeQ.delete();
        cleanQ.delete();
        ackLatency = 3;
        applyStimulus(5, 1'b1, 1'b1, 22'h155, rnd);
        runFlush("restart", 0, 0, NUM_LINES * 3 + 1 + 4, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
        $finish;
    end

endmodule
